lcd_pixel_gen: RTL and testbench

- Test-pattern pixel source sitting directly upstream of the LCD SPI writer.
- After the writer has sent the window setup (CASET/RASET) and the memory write command (0x2C), it pulls RGB565 pixels from this block over a valid/ready stream.
- On each start pulse, the block produces exactly one frame of WIDTH×HEIGHT pixels, in raster order (x fastest).
- Four selectable patterns are provided.

---
 rtl/lcd_pixel_gen_if.sv | 30 +++
 rtl/lcd_pixel_gen.sv | 169 ++++++++++++++++
 tb/tb_lcd_pixel_gen.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pixel_gen_if.sv
// rtl/lcd_pixel_gen_if.sv - RGB565 pixel stream between pattern source and LCD SPI writer
// Signals:
//   pix_valid  source -> sink  pix_data holds a valid pixel
//   pix_ready  sink -> source  sink accepts the pixel this cycle
//   pix_data   source -> sink  RGB565 pixel, R[15:11] G[10:5] B[4:0]
//   pix_sof    source -> sink  marks pixel (0,0)
//   pix_last   source -> sink  marks the final pixel of the frame
interface lcd_pixel_gen_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic        pix_sof;
  logic        pix_last;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_sof,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_sof,
    input  pix_last,
    output pix_ready
  );
endinterface

// File: rtl/lcd_pixel_gen.sv
// rtl/lcd_pixel_gen.sv - one-frame RGB565 test-pattern source for the LCD SPI writer
// Ports:
//   clk, rst_n  clock; asynchronous active-low reset
//   start       one-cycle frame request, accepted only in IDLE
//   mode        pattern select (0 bands, 1 checker, 2 gradient, 3 solid), latched at start
//   pix         lcd_pixel_gen_if.master pixel stream (valid/ready, sof, last)
//   busy        frame in progress
//   done        one-cycle pulse after the last pixel transfer
// Optional build macro: LCD_PIXEL_BORDER_EN forces the one-pixel window border
// to white in modes 0..2.
module lcd_pixel_gen #(
  parameter int          WIDTH      = 240,
  parameter int          HEIGHT     = 135,
  parameter logic [15:0] FILL_COLOR = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             mode,
  lcd_pixel_gen_if.master        pix,
  output logic                   busy,
  output logic                   done
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [1:0]    mode_q, mode_n;
  logic          valid_q, valid_n;
  logic [15:0]   data_q, data_n;
  logic          sof_q, sof_n;
  logic          last_q, last_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;

  logic [XW-1:0] x_inc;
  logic [YW-1:0] y_inc;

  function automatic logic [15:0] pixel(input logic [1:0] m,
                                        input logic [XW-1:0] px,
                                        input logic [YW-1:0] py);
    logic [7:0]  x8;
    logic [7:0]  y8;
    logic [15:0] p;
    x8 = 8'(px);
    y8 = 8'(py);
    case (m)
      2'd0: begin
        if (32'(py) < 32'(HEIGHT / 3))
          p = 16'h001F;
        else if (32'(py) < 32'((2 * HEIGHT) / 3))
          p = 16'h07E0;
        else
          p = 16'hF800;
      end
      2'd1:    p = (px[3] ^ py[3]) ? 16'hFFFF : 16'h0000;
      2'd2:    p = {x8[7:3], y8[7:2], ~x8[7:3]};
      default: p = FILL_COLOR;
    endcase
`ifdef LCD_PIXEL_BORDER_EN
    if ((m != 2'd3) &&
        ((px == '0) || (px == X_LAST) || (py == '0) || (py == Y_LAST)))
      p = 16'hFFFF;
`endif
    return p;
  endfunction

  // Raster advance: x runs fastest, y steps when x wraps.
  assign x_inc = (x == X_LAST) ? '0 : x + 1'b1;
  assign y_inc = (x == X_LAST) ? y + 1'b1 : y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      mode_q  <= 2'd0;
      valid_q <= 1'b0;
      data_q  <= 16'h0000;
      sof_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      x       <= x_n;
      y       <= y_n;
      mode_q  <= mode_n;
      valid_q <= valid_n;
      data_q  <= data_n;
      sof_q   <= sof_n;
      last_q  <= last_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    mode_n  = mode_q;
    valid_n = valid_q;
    data_n  = data_q;
    sof_n   = sof_q;
    last_n  = last_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          mode_n  = mode;
          x_n     = '0;
          y_n     = '0;
          busy_n  = 1'b1;
          valid_n = 1'b1;
          sof_n   = 1'b1;
          last_n  = (WIDTH == 1) && (HEIGHT == 1);
          // Uses the live mode input: the latched copy is not loaded yet.
          data_n  = pixel(mode, '0, '0);
        end
      end
      RUN: begin
        if (valid_q && pix.pix_ready) begin
          if (last_q) begin
            state_n = DONE;
            valid_n = 1'b0;
            sof_n   = 1'b0;
            last_n  = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            x_n    = x_inc;
            y_n    = y_inc;
            sof_n  = 1'b0;
            last_n = (x_inc == X_LAST) && (y_inc == Y_LAST);
            data_n = pixel(mode_q, x_inc, y_inc);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign pix.pix_valid = valid_q;
  assign pix.pix_data  = data_q;
  assign pix.pix_sof   = sof_q;
  assign pix.pix_last  = last_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_lcd_pixel_gen.sv
// tb/tb_lcd_pixel_gen.sv - scoreboard bench for lcd_pixel_gen
module tb_lcd_pixel_gen;

  localparam int W = 240;
  localparam int H = 135;
  localparam int N = W * H;
`ifdef LCD_PIXEL_BORDER_EN
  localparam logic [15:0] FILL = 16'h1234;
  localparam int          C_MODE = 3;
`else
  localparam logic [15:0] FILL = 16'hFFFF;
  localparam int          C_MODE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       busy;
  logic       done;

  lcd_pixel_gen_if pix_if ();
  assign pix_if.pix_ready = ready;

  lcd_pixel_gen #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .FILL_COLOR (FILL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .pix   (pix_if),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   mon_idx = 0;
  int   frames_done = 0;
  int   cyc = 0;
  logic tie_ready = 1'b0;
  int   frame_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input int m, input int x, input int y);
    int r, g, b;
    logic [15:0] p;
    case (m)
      0: begin
        b = (y * 3) / H;
        p = (b == 0) ? 16'h001F : (b == 1) ? 16'h07E0 : 16'hF800;
      end
      1: p = (((x / 8) + (y / 8)) % 2 == 1) ? 16'hFFFF : 16'h0000;
      2: begin
        r = (x / 8) % 32;
        g = (y / 4) % 64;
        p = 16'((r << 11) | (g << 5) | (31 - r));
      end
      default: p = FILL;
    endcase
`ifdef LCD_PIXEL_BORDER_EN
    if (m != 3 && (x == 0 || x == W - 1 || y == 0 || y == H - 1)) p = 16'hFFFF;
`endif
    return p;
  endfunction

  task automatic spot(input int m, input int idx, input logic [15:0] d, input logic l);
`ifndef LCD_PIXEL_BORDER_EN
    if (m == 0) begin
      if (idx == 0)     chk("m0_pix0", d, 16'h001F);
      if (idx == 10799) chk("m0_pix10799", d, 16'h001F);
      if (idx == 10800) chk("m0_pix10800", d, 16'h07E0);
      if (idx == 21599) chk("m0_pix21599", d, 16'h07E0);
      if (idx == 21600) chk("m0_pix21600", d, 16'hF800);
      if (idx == N - 1) chk("m0_last_flag", l, 1);
    end
    if (m == 1) begin
      if (idx == 0)    chk("m1_x0_y0", d, 16'h0000);
      if (idx == 7)    chk("m1_x7_y0", d, 16'h0000);
      if (idx == 8)    chk("m1_x8_y0", d, 16'hFFFF);
      if (idx == 1920) chk("m1_x0_y8", d, 16'hFFFF);
      if (idx == 1928) chk("m1_x8_y8", d, 16'h0000);
    end
    if (m == 2) begin
      if (idx == 0)   chk("m2_x0_y0", d, 16'h001F);
      if (idx == 968) chk("m2_x8_y4", d, 16'h083E);
      if (idx == N - 1) begin
        chk("m2_x239_y134", d, 16'hEC22);
        chk("m2_last_flag", l, 1);
      end
    end
`else
    if (m == 0) begin
      if (idx == 12000) chk("bd_x0_y50", d, 16'hFFFF);
      if (idx == 12001) chk("bd_x1_y50", d, 16'h07E0);
      if (idx == 12239) chk("bd_x239_y50", d, 16'hFFFF);
    end
    if (m == 3) begin
      if (idx == 0)   chk("bd_m3_corner", d, 16'h1234);
      if (idx == 500) chk("bd_m3_pix500", d, 16'h1234);
    end
`endif
  endtask

  // Monitor / scoreboard
  initial begin
    logic in_rst;
    logic stall;
    logic pend_start;
    logic exp_done;
    exp_t held;
    exp_t e;
    int   sof_cyc;
    in_rst = 1'b0;
    stall = 1'b0;
    pend_start = 1'b0;
    exp_done = 1'b0;
    held = '0;
    sof_cyc = 0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        if (!in_rst) begin
          #1;
          chk("rst_valid", pix_if.pix_valid, 0);
          chk("rst_data", pix_if.pix_data, 0);
          chk("rst_sof", pix_if.pix_sof, 0);
          chk("rst_last", pix_if.pix_last, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          in_rst = 1'b1;
        end
        exp_q.delete();
        stall = 1'b0;
        pend_start = 1'b0;
        exp_done = 1'b0;
        mon_idx = 0;
      end else begin
        in_rst = 1'b0;
        cyc++;
        if (exp_done) begin
          chk("done_after_last", done, 1);
          exp_done = 1'b0;
        end else begin
          chk("done_low", done, 0);
        end
        if (pend_start) begin
          chk("first_valid_latency", {pix_if.pix_valid, pix_if.pix_sof, busy}, 3'b111);
          pend_start = 1'b0;
        end
        if (stall && pix_if.pix_valid)
          chk("stall_hold", {pix_if.pix_data, pix_if.pix_sof, pix_if.pix_last}, held);
        if (pix_if.pix_valid && ready) begin
          if (exp_q.size() > 0) e = exp_q.pop_front();
          else e = 'x;
          chk($sformatf("data_idx%0d", mon_idx), pix_if.pix_data, e.data);
          chk($sformatf("sof_idx%0d", mon_idx), pix_if.pix_sof, e.sof);
          chk($sformatf("last_idx%0d", mon_idx), pix_if.pix_last, e.last);
          spot(frame_mode, mon_idx, pix_if.pix_data, pix_if.pix_last);
          if (mon_idx == 0) sof_cyc = cyc;
          if (e.last === 1'b1) begin
            exp_done = 1'b1;
            chk("frame_transfer_count", mon_idx + 1, N);
            if (tie_ready) chk("consecutive_transfers", cyc - sof_cyc, N - 1);
            frames_done++;
            mon_idx = 0;
          end else begin
            mon_idx++;
          end
        end
        stall = pix_if.pix_valid && !ready;
        held = {pix_if.pix_data, pix_if.pix_sof, pix_if.pix_last};
        if (start && !busy && !done) pend_start = 1'b1;
      end
    end
  end

  task automatic push_frame(input int m);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({model(m, x, y), (x == 0 && y == 0), (x == W - 1 && y == H - 1)});
  endtask

  task automatic start_frame(input int m);
    frame_mode = m;
    push_frame(m);
    @(posedge clk);
    #1 start = 1'b1;
    mode = 2'(m);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("frame_completed", 32'(frames_done >= target), 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ready = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  // Stimulus
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Frame A: mode 0, ready tied high, stray start and mode change mid-frame
    tie_ready = 1'b1;
    ready = 1'b1;
    start_frame(0);
    repeat (5000) @(posedge clk);
    #1 start = 1'b1;
    mode = 2'd2;
    @(posedge clk);
    #1 start = 1'b0;
    mode = 2'd3;
    wait_done(1, 40000);
    repeat (3) @(posedge clk);

    // Frame B: mode 1 with random back-pressure, aborted by reset
    tie_ready = 1'b0;
    start_frame(1);
    for (int n = 0; n < 10000 && mon_idx < 2000; n++) begin
      @(posedge clk);
      #1 ready = 1'($urandom_range(0, 1));
    end
    pulse_reset();

    // Frame C: aborted by reset after about 1000 transfers
    start_frame(C_MODE);
    repeat (1000) @(posedge clk);
    pulse_reset();

    // Frame D: mode 2 from a fresh start, stray start and mode change mid-frame
    tie_ready = 1'b1;
    ready = 1'b1;
    start_frame(2);
    repeat (7000) @(posedge clk);
    #1 start = 1'b1;
    mode = 2'd0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(2, 40000);
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
